// File: rtl/fp_pkg.sv
// Shared definitions for the FPU handshake sequencer: state codes,
// interrupt flag bit positions and the tick-counter preload helper.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_MEM   = 3'd3,
    S_OKP   = 3'd4,
    S_GOT   = 3'd5
  } state_e;

  // Bit positions of the active-high flags in irq_fp.
  // fi_ arrives as {fi0_, fi1_, fi2_, fi3_}, so fi0 sits in the MSB.
  localparam int FI0 = 3;  // fixed-point overflow
  localparam int FI1 = 2;  // FP underflow
  localparam int FI2 = 1;  // FP overflow
  localparam int FI3 = 0;  // divide by zero

  // Preload for the tick counter so that a phase lasts exactly 'ticks'
  // clocks (the zero flag ends the phase); 0 is treated as 1.
  function automatic logic [2:0] tick_init(input logic [2:0] ticks);
    return (ticks == 3'd0) ? 3'd0 : ticks - 3'd1;
  endfunction

endpackage

// File: rtl/fp_tick.sv
// Loadable 3-bit down-counter with zero flag; shared by the timed
// phases of the FPU handshake (start strobe, data-valid, acknowledge).
module fp_tick (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [2:0] val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [2:0] cnt_q;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 3'd0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (dec_i && (cnt_q != 3'd0)) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/fp_seq.sv
// CPU-side initiator for the FPU handshake: starts an operation, serves
// the FPU's memory reads, latches completion flags and acknowledges.
// A watchdog turns a stalled FPU into a done+alarm completion.
module fp_seq
  import fp_pkg::*;
#(
  parameter logic [2:0]  START_TICKS = 3'd3,
  parameter logic [2:0]  OK_TICKS    = 3'd3,
  parameter logic [2:0]  GOT_TICKS   = 3'd3,
  parameter logic [15:0] TIMEOUT     = 16'd2000
) (
  input  logic       __clk,
  input  logic       clr,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       nrf_in,
  output logic [2:0] ir,
  output logic       nrf,
  output logic       efp_,
  output logic       got_,
  output logic       ok$,
  input  logic       ekc_fp_,
  input  logic       sr_fp_,
  input  logic       read_fp_,
  output logic       mem_req,
  input  logic       mem_ok,
  input  logic       mem_err,
  input  logic [3:0] fi_,
  output logic [3:0] irq_fp,
  input  logic       irq_clr,
  output logic       busy,
  output logic       done,
  output logic       alarm
);

  state_e      state_q, state_d;
  logic        ph_q, ph_d;        // second half of OKP/GOT: timed phase over, waiting on FPU
  logic [15:0] wd_q, wd_d;
  logic        apend_q, apend_d;  // op will end with alarm
  logic [3:0]  irq_q, irq_d;
  logic [2:0]  ir_q, ir_d;
  logic        nrf_q, nrf_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        alarm_q, alarm_d;

  logic        tk_load, tk_dec, tk_zero;
  logic [2:0]  tk_val;
  logic        wd_hit;
  logic        latch;
  logic [3:0]  fi_act;

  fp_tick u_tick (
    .clk_i  (__clk),
    .rst_i  (clr),
    .load_i (tk_load),
    .val_i  (tk_val),
    .dec_i  (tk_dec),
    .zero_o (tk_zero)
  );

  assign wd_hit = (wd_q == TIMEOUT - 16'd1);

  // Flags from the FPU are active low; present them active high.
  always_comb begin
    fi_act      = 4'd0;
    fi_act[FI0] = ~fi_[3];
    fi_act[FI1] = ~fi_[2];
    fi_act[FI2] = ~fi_[1];
    fi_act[FI3] = ~fi_[0];
  end

  // Next-state, watchdog, tick control and latched-value updates.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    wd_d    = wd_q;
    apend_d = apend_q;
    ir_d    = ir_q;
    nrf_d   = nrf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    alarm_d = 1'b0;
    tk_load = 1'b0;
    tk_val  = 3'd0;
    tk_dec  = 1'b0;
    latch   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ir_d    = op;
          nrf_d   = nrf_in;
          busy_d  = 1'b1;
          apend_d = 1'b0;
          wd_d    = 16'd0;
          tk_load = 1'b1;
          tk_val  = tick_init(START_TICKS);
          state_d = S_START;
        end
      end

      S_START: begin
        if (tk_zero) begin
          wd_d    = 16'd0;
          state_d = S_RUN;
        end else begin
          tk_dec = 1'b1;
        end
      end

      S_RUN: begin
        wd_d = wd_q + 16'd1;
        if (!ekc_fp_) begin
          latch   = 1'b1;
          wd_d    = 16'd0;
          ph_d    = 1'b0;
          tk_load = 1'b1;
          tk_val  = tick_init(GOT_TICKS);
          state_d = S_GOT;
        end else if (wd_hit) begin
          apend_d = 1'b1;
          wd_d    = 16'd0;
          ph_d    = 1'b0;
          tk_load = 1'b1;
          tk_val  = tick_init(GOT_TICKS);
          state_d = S_GOT;
        end else if (!sr_fp_ && !read_fp_) begin
          state_d = S_MEM;
        end
      end

      S_MEM: begin
        wd_d = wd_q + 16'd1;
        if (mem_err || (!mem_ok && wd_hit)) begin
          apend_d = 1'b1;
          wd_d    = 16'd0;
          ph_d    = 1'b0;
          tk_load = 1'b1;
          tk_val  = tick_init(GOT_TICKS);
          state_d = S_GOT;
        end else if (mem_ok) begin
          ph_d    = 1'b0;
          tk_load = 1'b1;
          tk_val  = tick_init(OK_TICKS);
          state_d = S_OKP;
        end
      end

      S_OKP: begin
        // Hold ok$ for its ticks, then wait for the request to drop so
        // one request is never served twice.
        if (!ph_q) begin
          if (tk_zero) ph_d = 1'b1;
          else         tk_dec = 1'b1;
        end else if (sr_fp_) begin
          ph_d    = 1'b0;
          wd_d    = 16'd0;
          state_d = S_RUN;
        end
      end

      S_GOT: begin
        wd_d = wd_q + 16'd1;
        if (wd_hit) begin
          done_d  = 1'b1;
          alarm_d = 1'b1;
          busy_d  = 1'b0;
          apend_d = 1'b0;
          ph_d    = 1'b0;
          state_d = S_IDLE;
        end else if (!ph_q) begin
          if (tk_zero) ph_d = 1'b1;
          else         tk_dec = 1'b1;
        end else if (ekc_fp_) begin
          done_d  = 1'b1;
          alarm_d = apend_q;
          busy_d  = 1'b0;
          apend_d = 1'b0;
          ph_d    = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Sticky flags; a clear beats a latch in the same clock.
    if (irq_clr)    irq_d = 4'd0;
    else if (latch) irq_d = irq_q | fi_act;
    else            irq_d = irq_q;
  end

  // State and latched-value registers; reset aborts any operation.
  always_ff @(posedge __clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
      wd_q    <= 16'd0;
      apend_q <= 1'b0;
      irq_q   <= 4'd0;
      ir_q    <= 3'd0;
      nrf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      wd_q    <= wd_d;
      apend_q <= apend_d;
      irq_q   <= irq_d;
      ir_q    <= ir_d;
      nrf_q   <= nrf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
    end
  end

  assign efp_    = (state_q != S_START);
  assign got_    = !((state_q == S_GOT) && !ph_q);
  assign ok$     = (state_q == S_OKP) && !ph_q;
  assign mem_req = (state_q == S_MEM);
  assign ir      = ir_q;
  assign nrf     = nrf_q;
  assign irq_fp  = irq_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_fp_seq.sv
// Directed bench for fp_seq: a table of FPU transactions driven by a
// small FPU/memory model, plus hand sequences for timeout and reset.
module tb_fp_seq;

  logic       clk = 1'b0;
  logic       clr, start, nrf_in, ekc_fp_, sr_fp_, read_fp_;
  logic       mem_ok, mem_err, irq_clr;
  logic [2:0] op, ir;
  logic [3:0] fi_, irq_fp;
  logic       nrf, efp_, got_, ok_w, mem_req, busy, done, alarm;

  always #5 clk = ~clk;

  fp_seq #(.TIMEOUT(16'd50)) dut (
    .__clk    (clk),
    .clr      (clr),
    .start    (start),
    .op       (op),
    .nrf_in   (nrf_in),
    .ir       (ir),
    .nrf      (nrf),
    .efp_     (efp_),
    .got_     (got_),
    .ok$      (ok_w),
    .ekc_fp_  (ekc_fp_),
    .sr_fp_   (sr_fp_),
    .read_fp_ (read_fp_),
    .mem_req  (mem_req),
    .mem_ok   (mem_ok),
    .mem_err  (mem_err),
    .fi_      (fi_),
    .irq_fp   (irq_fp),
    .irq_clr  (irq_clr),
    .busy     (busy),
    .done     (done),
    .alarm    (alarm)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cumulative activity counters sampled on the falling edge.
  int   efp_lo_n = 0, got_lo_n = 0, ok_hi_n = 0, done_n = 0, memwin_n = 0;
  logic mem_req_prev = 1'b0;
  always @(negedge clk) begin
    if (efp_ === 1'b0) efp_lo_n <= efp_lo_n + 1;
    if (got_ === 1'b0) got_lo_n <= got_lo_n + 1;
    if (ok_w === 1'b1) ok_hi_n  <= ok_hi_n + 1;
    if (done === 1'b1) done_n   <= done_n + 1;
    if (mem_req === 1'b1 && mem_req_prev !== 1'b1) memwin_n <= memwin_n + 1;
    mem_req_prev <= mem_req;
  end

  typedef struct {
    logic [2:0] op;
    logic       nrf;
    logic [3:0] fi;
    int         reads;
    logic       err;
    logic       iclr;
    logic       bstart;
    logic [3:0] exp_irq;
    logic       exp_alarm;
    int         exp_ok;
  } vec_t;

  vec_t vecs[5];

  // Wait (bounded) for efp_ to pulse low and return high; ends in RUN.
  task automatic wait_start_done(input string tag);
    int g;
    g = 0;
    while (efp_ !== 1'b0 && g < 10) begin @(negedge clk); g++; end
    while (efp_ !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    if (g >= 20) check({tag, " efp_ strobe"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int e0, g0, o0, d0, w0, g;
    @(negedge clk);
    e0 = efp_lo_n; g0 = got_lo_n; o0 = ok_hi_n; d0 = done_n; w0 = memwin_n;
    start = 1'b1; op = v.op; nrf_in = v.nrf;
    @(negedge clk);
    start = 1'b0; op = 3'b000; nrf_in = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    wait_start_done(tag);
    if (v.bstart) begin
      start = 1'b1; op = ~v.op; nrf_in = ~v.nrf;
      @(negedge clk);
      start = 1'b0; op = 3'b000; nrf_in = 1'b0;
    end
    for (int r = 0; r < v.reads; r++) begin
      repeat (2) @(negedge clk);
      sr_fp_ = 1'b0; read_fp_ = 1'b0;
      repeat (4) @(negedge clk);
      if (v.err) mem_err = 1'b1; else mem_ok = 1'b1;
      @(negedge clk);
      mem_ok = 1'b0; mem_err = 1'b0;
      if (!v.err) begin
        g = 0;
        while (ok_w !== 1'b1 && g < 10) begin @(negedge clk); g++; end
        while (ok_w !== 1'b0 && g < 20) begin @(negedge clk); g++; end
        if (g >= 20) check({tag, " ok$ window"}, 32'd0, 32'd1);
      end
      sr_fp_ = 1'b1; read_fp_ = 1'b1;
    end
    if (!v.err) begin
      repeat (10) @(negedge clk);
      ekc_fp_ = 1'b0; fi_ = v.fi; irq_clr = v.iclr;
      @(negedge clk);
      irq_clr = 1'b0;
      @(negedge clk);
      ekc_fp_ = 1'b1; fi_ = 4'hF;
    end
    g = 0;
    while (done !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    check({tag, " done seen"}, 32'(done), 32'd1);
    check({tag, " alarm"}, 32'(alarm), 32'(v.exp_alarm));
    check({tag, " busy end"}, 32'(busy), 32'd0);
    check({tag, " ir"}, 32'(ir), 32'(v.op));
    check({tag, " nrf"}, 32'(nrf), 32'(v.nrf));
    check({tag, " irq_fp"}, 32'(irq_fp), 32'(v.exp_irq));
    @(negedge clk);
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " efp_ low clks"}, 32'(efp_lo_n - e0), 32'd3);
    check({tag, " got_ low clks"}, 32'(got_lo_n - g0), 32'd3);
    check({tag, " ok$ high clks"}, 32'(ok_hi_n - o0), 32'(v.exp_ok));
    check({tag, " mem_req windows"}, 32'(memwin_n - w0), 32'(v.reads));
    check({tag, " done count"}, 32'(done_n - d0), 32'd1);
  endtask

  initial begin
    int g, run_cnt, g0, d0;
    //            op      nrf   fi       rd err  iclr bst  irq      alm  ok
    vecs[0] = '{3'b101, 1'b0, 4'b1111, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 0};
    vecs[1] = '{3'b011, 1'b1, 4'b1111, 2, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 6};
    vecs[2] = '{3'b110, 1'b0, 4'b0110, 0, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, 0};
    vecs[3] = '{3'b001, 1'b1, 4'b1110, 0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 0};
    vecs[4] = '{3'b010, 1'b0, 4'b1111, 1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 0};

    clr = 1'b1; start = 1'b0; op = 3'b000; nrf_in = 1'b0;
    ekc_fp_ = 1'b1; sr_fp_ = 1'b1; read_fp_ = 1'b1;
    mem_ok = 1'b0; mem_err = 1'b0; fi_ = 4'hF; irq_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst efp_",    32'(efp_),    32'd1);
    check("rst got_",    32'(got_),    32'd1);
    check("rst ok$",     32'(ok_w),    32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst busy",    32'(busy),    32'd0);
    check("rst done",    32'(done),    32'd0);
    check("rst alarm",   32'(alarm),   32'd0);
    check("rst irq_fp",  32'(irq_fp),  32'd0);
    check("rst ir",      32'(ir),      32'd0);
    check("rst nrf",     32'(nrf),     32'd0);
    clr = 1'b0;

    for (int i = 0; i < 5; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Silent FPU: watchdog ends the op after 50 clocks in RUN.
    @(negedge clk);
    g0 = got_lo_n; d0 = done_n;
    start = 1'b1; op = 3'b100;
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    wait_start_done("tmo");
    run_cnt = 0;
    while (got_ === 1'b1 && run_cnt < 200) begin run_cnt++; @(negedge clk); end
    check("tmo RUN clks", 32'(run_cnt), 32'd50);
    g = 0;
    while (done !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    check("tmo done", 32'(done), 32'd1);
    check("tmo alarm", 32'(alarm), 32'd1);
    check("tmo busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("tmo got_ low clks", 32'(got_lo_n - g0), 32'd3);
    check("tmo done count", 32'(done_n - d0), 32'd1);

    // Reset while ok$ is high aborts with no done.
    start = 1'b1; op = 3'b111;
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    wait_start_done("rst_okp");
    sr_fp_ = 1'b0; read_fp_ = 1'b0;
    repeat (3) @(negedge clk);
    mem_ok = 1'b1;
    @(negedge clk);
    mem_ok = 1'b0;
    check("okp ok$ high", 32'(ok_w), 32'd1);
    d0 = done_n;
    clr = 1'b1;
    #1;
    check("okp clr ok$",  32'(ok_w), 32'd0);
    check("okp clr efp_", 32'(efp_), 32'd1);
    check("okp clr got_", 32'(got_), 32'd1);
    check("okp clr busy", 32'(busy), 32'd0);
    check("okp clr ir",   32'(ir),   32'd0);
    @(negedge clk);
    sr_fp_ = 1'b1; read_fp_ = 1'b1; clr = 1'b0;
    repeat (8) @(negedge clk);
    check("okp no done", 32'(done_n - d0), 32'd0);
    run_op(vecs[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
